tlp_eth_arbiter: RTL and testbench

// Packet-granular round-robin arbiter merging two AXI4-Stream TLP sources (port 0: PCIe completer

---
 rtl/tlp_eth_arbiter_if.sv | 49 ++++
 rtl/tlp_eth_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_tlp_eth_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlp_eth_arbiter_if.sv
// ---------------------------------------------------------------------------
// tlp_eth_arbiter_if
// AXI4-Stream bundle used for both the TLP sources and the merged Ethernet TX
// stream of tlp_eth_arbiter.
//
// Signals
//   tdata  [DATA_WIDTH-1:0]  beat payload
//   tkeep  [KEEP_WIDTH-1:0]  one bit per dword of tdata
//   tuser  [USER_WIDTH-1:0]  sideband, carried through untouched
//   tlast                    last beat of a packet
//   tvalid                   source has a beat
//   tready                   sink takes the beat
//
// Modports
//   master : drives the stream (tdata..tvalid out, tready in)
//   slave  : receives the stream (tdata..tvalid in, tready out)
// ---------------------------------------------------------------------------
interface tlp_eth_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int USER_WIDTH = 85
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface : tlp_eth_arbiter_if

// File: rtl/tlp_eth_arbiter.sv
// ---------------------------------------------------------------------------
// tlp_eth_arbiter
// Packet-granular round-robin arbiter that merges two AXI4-Stream TLP sources
// (port 0: PCIe completer requests, port 1: local status / loopback) onto the
// single Ethernet TX stream. A grant is held for a whole packet. Packets longer
// than MAX_BEATS are cut: the MAX_BEATS-th beat goes out with tlast forced and
// the rest of the input packet is swallowed. Per-port packet counters and a
// shared truncation counter are kept.
//
// Parameters
//   C_DATA_WIDTH  tdata width of every stream
//   KEEP_WIDTH    tkeep width (one bit per dword)
//   USER_WIDTH    tuser width, passed through unmodified
//   MAX_BEATS     maximum beats per output packet (>= 2)
//
// Ports
//   user_clk    in   clock, everything on the rising edge
//   user_reset  in   synchronous active-high reset
//   s0_axis     slave   port-0 input stream
//   s1_axis     slave   port-1 input stream
//   m_axis      master  merged output stream (one register slice)
//   pkt_cnt0    out  packets forwarded from port 0 (wraps)
//   pkt_cnt1    out  packets forwarded from port 1 (wraps)
//   trunc_cnt   out  packets truncated on either port (saturates)
//   busy        out  high whenever a packet is being passed or drained
// ---------------------------------------------------------------------------
module tlp_eth_arbiter #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int USER_WIDTH   = 85,
  parameter int MAX_BEATS    = 64
) (
  input  logic        user_clk,
  input  logic        user_reset,
  tlp_eth_arbiter_if.slave  s0_axis,
  tlp_eth_arbiter_if.slave  s1_axis,
  tlp_eth_arbiter_if.master m_axis,
  output logic [31:0] pkt_cnt0,
  output logic [31:0] pkt_cnt1,
  output logic [15:0] trunc_cnt,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE,   // waiting for any source, arbitration happens here
    PASS,   // forwarding the granted packet to m_axis
    DRAIN   // discarding the tail of a truncated packet
  } state_t;

  state_t             state;
  state_t             state_d;
  logic               grant;       // port currently owning the output
  logic               last_grant;  // port that finished the previous packet
  logic [CNT_W-1:0]   beat_cnt;    // beats accepted in the current packet

  // Muxed view of the granted input port.
  logic [C_DATA_WIDTH-1:0] in_tdata;
  logic [KEEP_WIDTH-1:0]   in_tkeep;
  logic [USER_WIDTH-1:0]   in_tuser;
  logic                    in_tlast;
  logic                    in_tvalid;
  logic                    in_ready;

  logic adv;        // output slice can take a new beat this cycle
  logic accept;     // granted port hands over a beat this cycle
  logic pass_beat;  // accepted beat goes to the output slice
  logic at_limit;   // current beat is the MAX_BEATS-th of the packet
  logic any_valid;
  logic pick;       // round-robin winner, meaningful only in IDLE

  // -------------------------------------------------------------------------
  // Next-state and handshake logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch can form.
    state_d   = state;
    in_ready  = 1'b0;

    in_tdata  = grant ? s1_axis.tdata  : s0_axis.tdata;
    in_tkeep  = grant ? s1_axis.tkeep  : s0_axis.tkeep;
    in_tuser  = grant ? s1_axis.tuser  : s0_axis.tuser;
    in_tlast  = grant ? s1_axis.tlast  : s0_axis.tlast;
    in_tvalid = grant ? s1_axis.tvalid : s0_axis.tvalid;

    adv       = !m_axis.tvalid || m_axis.tready;
    at_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    any_valid = s0_axis.tvalid || s1_axis.tvalid;

    // On a tie the port that did not finish the previous packet wins;
    // otherwise whichever port is valid (port 1 iff only port 1 is valid).
    pick = (s0_axis.tvalid && s1_axis.tvalid) ? ~last_grant : s1_axis.tvalid;

    // The drain path does not touch the output slice, so it never stalls.
    case (state)
      PASS:    in_ready = adv;
      DRAIN:   in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase

    accept    = in_tvalid && in_ready;
    pass_beat = (state == PASS) && accept;

    case (state)
      IDLE: begin
        if (any_valid) state_d = PASS;
      end
      PASS: begin
        if (accept) begin
          if (in_tlast)      state_d = IDLE;
          else if (at_limit) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && in_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s0_axis.tready = in_ready && !grant;
  assign s1_axis.tready = in_ready &&  grant;
  assign busy           = (state != IDLE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge user_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (user_reset) state <= IDLE;
    else            state <= state_d;
  end

  // -------------------------------------------------------------------------
  // Grant, beat counter, output slice and statistics
  // -------------------------------------------------------------------------
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      // NOTE: the output payload registers are reset too, so the stream comes
      // out of reset with all-zero data rather than stale contents.
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      beat_cnt      <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tuser  <= '0;
      pkt_cnt0      <= '0;
      pkt_cnt1      <= '0;
      trunc_cnt     <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        grant    <= pick;
        beat_cnt <= '0;
      end

      // Payload only loads on a real beat, so it holds while stalled and
      // after tvalid drops.
      if (adv) begin
        m_axis.tvalid <= pass_beat;
        if (pass_beat) begin
          m_axis.tdata <= in_tdata;
          m_axis.tkeep <= in_tkeep;
          m_axis.tuser <= in_tuser;
          m_axis.tlast <= in_tlast || at_limit;
        end
      end

      if (pass_beat) begin
        beat_cnt <= beat_cnt + 1'b1;

        // A packet is counted when its final output beat leaves, whether it
        // ended naturally or was cut at the limit.
        if (in_tlast || at_limit) begin
          if (grant) pkt_cnt1 <= pkt_cnt1 + 32'd1;
          else       pkt_cnt0 <= pkt_cnt0 + 32'd1;
        end

        // A tlast landing exactly on the limit beat is a full-length packet,
        // not a truncation.
        if (!in_tlast && at_limit && trunc_cnt != 16'hffff)
          trunc_cnt <= trunc_cnt + 16'd1;

        if (in_tlast) last_grant <= grant;
      end

      // A truncated packet only releases the port once its real tail is gone.
      if (state == DRAIN && accept && in_tlast) last_grant <= grant;
    end
  end

endmodule : tlp_eth_arbiter

// File: tb/tb_tlp_eth_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlp_eth_arbiter
// Directed bench for tlp_eth_arbiter with MAX_BEATS = 4. A background process
// plays per-port beat queues into the sources, drives m_axis.tready and
// records every output beat with the cycle it was seen in. Each test task
// loads stimulus, waits (bounded) and compares against hand-built expectations.
// ---------------------------------------------------------------------------
module tb_tlp_eth_arbiter;

  localparam int DW   = 64;
  localparam int KW   = DW / 32;
  localparam int UW   = 85;
  localparam int MAXB = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic        user_clk = 1'b0;
  logic        user_reset;
  logic [31:0] pkt_cnt0;
  logic [31:0] pkt_cnt1;
  logic [15:0] trunc_cnt;
  logic        busy;

  always #5 user_clk = ~user_clk;

  tlp_eth_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s0_axis ();
  tlp_eth_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s1_axis ();
  tlp_eth_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_axis ();

  tlp_eth_arbiter #(
    .C_DATA_WIDTH (DW),
    .KEEP_WIDTH   (KW),
    .USER_WIDTH   (UW),
    .MAX_BEATS    (MAXB)
  ) dut (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .s0_axis    (s0_axis),
    .s1_axis    (s1_axis),
    .m_axis     (m_axis),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .trunc_cnt  (trunc_cnt),
    .busy       (busy)
  );

  beat_t q0[$];
  beat_t q1[$];
  beat_t rx[$];
  beat_t exp_q[$];
  int    rx_cyc[$];
  int    cyc;
  int    start0;
  bit    rdy_rand;
  int    stall_cnt;
  int    stall_viol;
  int    total;
  int    bad;

  function automatic beat_t mk(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.keep = d[KW-1:0] ^ {KW{1'b1}};
    b.user = {d[20:0], d};
    b.last = l;
    return b;
  endfunction

  function automatic beat_t rnd_beat(input logic l);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = KW'($urandom);
    b.user = {21'($urandom), $urandom, $urandom};
    b.last = l;
    return b;
  endfunction

  function automatic bit same(input beat_t a, input beat_t b);
    return (a.data === b.data) && (a.keep === b.keep) &&
           (a.user === b.user) && (a.last === b.last);
  endfunction

  // -------------------------------------------------------------------------
  // Source / sink player
  // -------------------------------------------------------------------------
  initial begin
    bit    hs0, hs1, prev_stall;
    beat_t prev, cur, tmp;
    s0_axis.tvalid = 1'b0; s0_axis.tlast = 1'b0; s0_axis.tdata = '0;
    s0_axis.tkeep  = '0;   s0_axis.tuser = '0;
    s1_axis.tvalid = 1'b0; s1_axis.tlast = 1'b0; s1_axis.tdata = '0;
    s1_axis.tkeep  = '0;   s1_axis.tuser = '0;
    m_axis.tready  = 1'b1;
    cyc = 0; start0 = 0; prev_stall = 1'b0;
    forever begin
      @(negedge user_clk);
      hs0 = s0_axis.tvalid && s0_axis.tready;
      hs1 = s1_axis.tvalid && s1_axis.tready;
      cur.data = m_axis.tdata; cur.keep = m_axis.tkeep;
      cur.user = m_axis.tuser; cur.last = m_axis.tlast;
      if (m_axis.tvalid && m_axis.tready) begin
        rx.push_back(cur);
        rx_cyc.push_back(cyc);
      end
      if (prev_stall && !user_reset) begin
        stall_cnt++;
        if (m_axis.tvalid !== 1'b1 || !same(cur, prev)) stall_viol++;
      end
      prev_stall = m_axis.tvalid && !m_axis.tready && !user_reset;
      prev       = cur;

      @(posedge user_clk);
      cyc++;
      #1;
      if (hs0 && q0.size() > 0) tmp = q0.pop_front();
      if (hs1 && q1.size() > 0) tmp = q1.pop_front();
      if (q0.size() > 0 && !s0_axis.tvalid) start0 = cyc;
      if (q0.size() > 0) begin
        s0_axis.tvalid = 1'b1;        s0_axis.tdata = q0[0].data;
        s0_axis.tkeep  = q0[0].keep;  s0_axis.tuser = q0[0].user;
        s0_axis.tlast  = q0[0].last;
      end else begin
        s0_axis.tvalid = 1'b0;
      end
      if (q1.size() > 0) begin
        s1_axis.tvalid = 1'b1;        s1_axis.tdata = q1[0].data;
        s1_axis.tkeep  = q1[0].keep;  s1_axis.tuser = q1[0].user;
        s1_axis.tlast  = q1[0].last;
      end else begin
        s1_axis.tvalid = 1'b0;
      end
      m_axis.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clear_rx();
    rx.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_rx(input int n, input string name);
    int budget;
    budget = 300;
    while (rx.size() < n && budget > 0) begin
      @(negedge user_clk);
      budget--;
    end
    repeat (4) @(negedge user_clk);
    total++;
    if (rx.size() != n) begin
      bad++;
      $display("FAIL %s beat count: got %0d want %0d", name, rx.size(), n);
    end
  endtask

  task automatic wait_q_empty(input string name);
    int budget;
    budget = 300;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      @(negedge user_clk);
      budget--;
    end
    repeat (3) @(negedge user_clk);
    total++;
    if (q0.size() > 0 || q1.size() > 0) begin
      bad++;
      $display("FAIL %s sources stuck: q0=%0d q1=%0d", name, q0.size(), q1.size());
    end
  endtask

  task automatic cmp_rx(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx.size() || !same(rx[i], exp_q[i])) begin
        bad++;
        $display("FAIL %s beat %0d: got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                 name, i,
                 (i < rx.size()) ? rx[i].data : '0, (i < rx.size()) ? rx[i].keep : '0,
                 (i < rx.size()) ? rx[i].last : 1'b0,
                 exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    user_reset = 1'b1;
    repeat (3) @(negedge user_clk);
    total++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0) begin
      bad++;
      $display("FAIL reset m_valid/last: got %b/%b want 0/0", m_axis.tvalid, m_axis.tlast);
    end
    total++;
    if (m_axis.tdata !== '0 || m_axis.tkeep !== '0 || m_axis.tuser !== '0) begin
      bad++;
      $display("FAIL reset m_payload: got data=%h keep=%h want 0", m_axis.tdata, m_axis.tkeep);
    end
    total++;
    if (s0_axis.tready !== 1'b0 || s1_axis.tready !== 1'b0) begin
      bad++;
      $display("FAIL reset s_tready: got %b/%b want 0/0", s0_axis.tready, s1_axis.tready);
    end
    total++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0 || trunc_cnt !== 16'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset counters: got %h %h %h busy=%b want 0 0 0 0",
               pkt_cnt0, pkt_cnt1, trunc_cnt, busy);
    end
    user_reset = 1'b0;
    repeat (2) @(negedge user_clk);
    total++;
    if (busy !== 1'b0 || m_axis.tvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset idle: got busy=%b m_valid=%b want 0 0", busy, m_axis.tvalid);
    end
  endtask

  // Both ports loaded together right after reset: port 0 wins the first tie,
  // then the grant alternates packet by packet.
  task automatic test_round_robin();
    clear_rx();
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 2; b++) begin
        q0.push_back(mk(64'(32'h100 + k * 2 + b), b == 1));
        q1.push_back(mk(64'(32'h200 + k * 2 + b), b == 1));
      end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(64'(32'h100 + k * 2), 1'b0));
      exp_q.push_back(mk(64'(32'h101 + k * 2), 1'b1));
      exp_q.push_back(mk(64'(32'h200 + k * 2), 1'b0));
      exp_q.push_back(mk(64'(32'h201 + k * 2), 1'b1));
    end
    wait_rx(8, "rr");
    cmp_rx("rr");
    total++;
    if (pkt_cnt0 !== 32'd2 || pkt_cnt1 !== 32'd2) begin
      bad++;
      $display("FAIL rr pkt_cnt: got %0d/%0d want 2/2", pkt_cnt0, pkt_cnt1);
    end
  endtask

  // Lone 3-beat packet: beats show up 2, 3 and 4 cycles after tvalid rises.
  task automatic test_single_port0();
    clear_rx();
    for (int b = 0; b < 3; b++) begin
      q0.push_back(mk(64'(32'hA0 + b), b == 2));
      exp_q.push_back(mk(64'(32'hA0 + b), b == 2));
    end
    wait_rx(3, "single");
    cmp_rx("single");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= rx_cyc.size() || rx_cyc[i] != start0 + 2 + i) begin
        bad++;
        $display("FAIL single latency beat %0d: got cycle %0d want %0d", i,
                 (i < rx_cyc.size()) ? rx_cyc[i] - start0 : -1, 2 + i);
      end
    end
    total++;
    if (pkt_cnt0 !== 32'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single pkt_cnt0/busy: got %0d/%b want 3/0", pkt_cnt0, busy);
    end
  endtask

  // 6-beat packet is cut at 4 beats; an exact 4-beat packet is not a truncation.
  task automatic test_truncation();
    clear_rx();
    for (int b = 0; b < 6; b++) q1.push_back(mk(64'(32'h300 + b), b == 5));
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(64'(32'h300 + b), b == 3));
    wait_q_empty("trunc6");
    wait_rx(4, "trunc6");
    cmp_rx("trunc6");
    total++;
    if (trunc_cnt !== 16'd1 || pkt_cnt1 !== 32'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL trunc6 counters: got trunc=%0d pkt1=%0d busy=%b want 1 3 0",
               trunc_cnt, pkt_cnt1, busy);
    end

    clear_rx();
    for (int b = 0; b < 4; b++) begin
      q1.push_back(mk(64'(32'h400 + b), b == 3));
      exp_q.push_back(mk(64'(32'h400 + b), b == 3));
    end
    wait_rx(4, "exact4");
    cmp_rx("exact4");
    total++;
    if (trunc_cnt !== 16'd1 || pkt_cnt1 !== 32'd4) begin
      bad++;
      $display("FAIL exact4 counters: got trunc=%0d pkt1=%0d want 1 4", trunc_cnt, pkt_cnt1);
    end
  endtask

  // Random output stalls: data must match exactly and hold while stalled.
  // Port 1 finished last, so port 0 goes first on the tie.
  task automatic test_back_pressure();
    beat_t a[3], b[2], c[4];
    clear_rx();
    stall_cnt  = 0;
    stall_viol = 0;
    for (int i = 0; i < 3; i++) a[i] = rnd_beat(i == 2);
    for (int i = 0; i < 2; i++) b[i] = rnd_beat(i == 1);
    for (int i = 0; i < 4; i++) c[i] = rnd_beat(i == 3);
    foreach (a[i]) begin q0.push_back(a[i]); exp_q.push_back(a[i]); end
    foreach (b[i]) begin q1.push_back(b[i]); exp_q.push_back(b[i]); end
    foreach (c[i]) begin q0.push_back(c[i]); exp_q.push_back(c[i]); end
    rdy_rand = 1'b1;
    wait_rx(9, "bp");
    rdy_rand = 1'b0;
    repeat (2) @(negedge user_clk);
    cmp_rx("bp");
    total++;
    if (stall_viol != 0) begin
      bad++;
      $display("FAIL bp stability: got %0d unstable stalled cycles want 0", stall_viol);
    end
    total++;
    if (stall_cnt == 0) begin
      bad++;
      $display("FAIL bp stalls seen: got 0 want >0");
    end
    total++;
    if (pkt_cnt0 !== 32'd5 || pkt_cnt1 !== 32'd5 || trunc_cnt !== 16'd1) begin
      bad++;
      $display("FAIL bp counters: got %0d %0d %0d want 5 5 1", pkt_cnt0, pkt_cnt1, trunc_cnt);
    end
  endtask

  // Reset lands while the 2nd beat of a 5-beat packet is offered.
  task automatic test_reset_mid_packet();
    int budget;
    clear_rx();
    for (int b = 0; b < 5; b++) q0.push_back(mk(64'(32'h500 + b), b == 4));
    budget = 100;
    while (q0.size() != 4 && budget > 0) begin
      @(negedge user_clk);
      budget--;
    end
    total++;
    if (q0.size() != 4) begin
      bad++;
      $display("FAIL rstmid first beat: got q0=%0d want 4", q0.size());
    end
    user_reset = 1'b1;
    q0.delete();
    @(negedge user_clk);
    total++;
    if (m_axis.tvalid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid outputs: got m_valid=%b busy=%b want 0 0", m_axis.tvalid, busy);
    end
    total++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0 || trunc_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rstmid counters: got %h %h %h want 0", pkt_cnt0, pkt_cnt1, trunc_cnt);
    end
    user_reset = 1'b0;
    @(negedge user_clk);
    clear_rx();
    for (int b = 0; b < 3; b++) begin
      q0.push_back(mk(64'(32'h600 + b), b == 2));
      exp_q.push_back(mk(64'(32'h600 + b), b == 2));
    end
    wait_rx(3, "rstmid_next");
    cmp_rx("rstmid_next");
    total++;
    if (pkt_cnt0 !== 32'd1) begin
      bad++;
      $display("FAIL rstmid_next pkt_cnt0: got %0d want 1", pkt_cnt0);
    end
  endtask

  // Packet counter wraps; truncation counter saturates.
  task automatic test_wrap_saturate();
    force dut.pkt_cnt0 = 32'hffff_fffe;
    force dut.trunc_cnt = 16'hfffe;
    #1;
    release dut.pkt_cnt0;
    release dut.trunc_cnt;
    @(negedge user_clk);
    total++;
    if (pkt_cnt0 !== 32'hffff_fffe || trunc_cnt !== 16'hfffe) begin
      bad++;
      $display("FAIL wrap preload: got %h %h want fffffffe fffe", pkt_cnt0, trunc_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      clear_rx();
      q0.push_back(mk(64'(32'h700 + k), 1'b1));
      wait_rx(1, "wrap_pkt");
      total++;
      if (pkt_cnt0 !== ((k == 0) ? 32'hffff_ffff : 32'h0000_0000)) begin
        bad++;
        $display("FAIL wrap pkt_cnt0 step %0d: got %h want %h", k, pkt_cnt0,
                 (k == 0) ? 32'hffff_ffff : 32'h0000_0000);
      end
    end
    for (int k = 0; k < 2; k++) begin
      clear_rx();
      for (int b = 0; b < 6; b++) q1.push_back(mk(64'(32'h800 + b), b == 5));
      wait_q_empty("sat");
      total++;
      if (trunc_cnt !== 16'hffff) begin
        bad++;
        $display("FAIL sat trunc_cnt step %0d: got %h want ffff", k, trunc_cnt);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rdy_rand = 1'b0;
    test_reset();
    test_round_robin();
    test_single_port0();
    test_truncation();
    test_back_pressure();
    test_reset_mid_packet();
    test_wrap_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule : tb_tlp_eth_arbiter
